// File: rtl/seq_pattern_detector.sv
// Serial sequence detector for a programmable PAT_W-bit pattern. It supports an input qualifier,
// overlapping and non-overlapping detection, and a saturating match counter.
module seq_pattern_detector #(
  parameter int unsigned         PAT_W       = 3,
  parameter logic [PAT_W-1:0]    DEFAULT_PAT = PAT_W'(3'b101),
  parameter int unsigned         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PAT_W-1:0]    pattern_q, pattern_d;
  logic [PAT_W-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                out_q, out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;

  logic [PAT_W-1:0]    hist_shift_c;
  logic [FILL_W-1:0]   fill_inc_c;
  logic                match_c;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_FILL;
      pattern_q <= DEFAULT_PAT;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  // Candidate shift and match evaluation for the current bit.
  always_comb begin
    hist_shift_c = {hist_q[PAT_W-2:0], in};
    fill_inc_c   = (state_q == ST_ARMED) ? fill_q : FILL_W'(fill_q + FILL_W'(1));
    match_c      = in_valid && !pat_load &&
                   (fill_inc_c == FILL_FULL) && (hist_shift_c == pattern_q);
  end

  // Next-state: pattern, history, fill and FSM state.
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      if (match_c && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift_c;
        fill_d = fill_inc_c;
      end
    end
    state_d = (fill_d == FILL_FULL) ? ST_ARMED : ST_FILL;
  end

  // Outputs: match pulse and saturating counter; a clear beats a same-edge match.
  always_comb begin
    out_d = match_c;
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match_c && (cnt_q != CNT_MAX)) begin
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end
    sat_d = (cnt_d == CNT_MAX);
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: a 3-bit/2-bit-counter instance and a 4-bit instance
// share one stimulus stream.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit;
  logic       in_valid;
  logic       overlap;
  logic       pat_load;
  logic [2:0] pat_in_a;
  logic [3:0] pat_in_b;
  logic       cnt_clr;

  logic       out_a;
  logic [1:0] cnt_a;
  logic       sat_a;
  logic       out_b;
  logic [7:0] cnt_b;
  logic       sat_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(3), .DEFAULT_PAT(3'b101), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in_a), .cnt_clr(cnt_clr),
    .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_pattern_detector #(.PAT_W(4), .DEFAULT_PAT(4'b0110), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in_b), .cnt_clr(cnt_clr),
    .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int edges);
    reset = 1'b0;
    repeat (edges) tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in_bit = 1'b0; in_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in_a = '0; pat_in_b = '0; cnt_clr = 1'b0;

    // Reset state and default pattern 101, overlapping
    do_reset(2);
    chk("rst_out", 32'(out_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_sat", 32'(sat_a), 32'd0);
    step(1, 1); chk("ov_b1", 32'(out_a), 32'd0);
    step(1, 0); chk("ov_b2", 32'(out_a), 32'd0);
    step(1, 1); chk("ov_b3", 32'(out_a), 32'd1);
    step(1, 0); chk("ov_b4", 32'(out_a), 32'd0);
    step(1, 1); chk("ov_b5", 32'(out_a), 32'd1);
    chk("ov_cnt", 32'(cnt_a), 32'd2);

    // Non-overlap: the second 101 shares bit 3, so no second pulse
    do_reset(1);
    overlap = 1'b0;
    step(1, 1); chk("no_b1", 32'(out_a), 32'd0);
    step(1, 0); chk("no_b2", 32'(out_a), 32'd0);
    step(1, 1); chk("no_b3", 32'(out_a), 32'd1);
    step(1, 0); chk("no_b4", 32'(out_a), 32'd0);
    step(1, 1); chk("no_b5", 32'(out_a), 32'd0);
    chk("no_cnt", 32'(cnt_a), 32'd1);

    // Qualifier gaps hold a partial match
    do_reset(1);
    overlap = 1'b1;
    step(1, 1); chk("gap_b1", 32'(out_a), 32'd0);
    step(0, 1); chk("gap_g1", 32'(out_a), 32'd0);
    step(1, 0); chk("gap_b2", 32'(out_a), 32'd0);
    step(0, 1); chk("gap_g2", 32'(out_a), 32'd0);
    step(0, 1); chk("gap_g3", 32'(out_a), 32'd0);
    step(1, 1); chk("gap_b3", 32'(out_a), 32'd1);
    chk("gap_cnt", 32'(cnt_a), 32'd1);

    // Saturation on the 2-bit counter: 10101010101 gives five matches
    do_reset(1);
    for (int i = 0; i < 11; i++) step(1, (i % 2) == 0);
    chk("sat_cnt", 32'(cnt_a), 32'd3);
    chk("sat_flag", 32'(sat_a), 32'd1);
    chk("sat_out", 32'(out_a), 32'd1);
    step(1, 0);
    cnt_clr = 1'b1;
    step(1, 1);
    cnt_clr = 1'b0;
    chk("clr_out", 32'(out_a), 32'd1);
    chk("clr_cnt", 32'(cnt_a), 32'd0);
    chk("clr_sat", 32'(sat_a), 32'd0);
    step(1, 0);
    step(1, 1);
    chk("clr_recount", 32'(cnt_a), 32'd1);

    // Pattern load 1111 on the 4-bit instance, consecutive overlapping matches
    do_reset(1);
    pat_load = 1'b1; pat_in_b = 4'b1111; pat_in_a = 3'b111;
    tick();
    pat_load = 1'b0;
    step(1, 1); chk("ld_b1", 32'(out_b), 32'd0);
    step(1, 1); chk("ld_b2", 32'(out_b), 32'd0);
    step(1, 1); chk("ld_b3", 32'(out_b), 32'd0);
    step(1, 1); chk("ld_b4", 32'(out_b), 32'd1);
    step(1, 1); chk("ld_b5", 32'(out_b), 32'd1);
    step(1, 1); chk("ld_b6", 32'(out_b), 32'd1);
    chk("ld_cnt", 32'(cnt_b), 32'd3);

    // pat_load with a valid bit: bit dropped, fill restarts, counter kept
    pat_load = 1'b1;
    step(1, 1);
    pat_load = 1'b0;
    chk("ldv_out", 32'(out_b), 32'd0);
    chk("ldv_cnt", 32'(cnt_b), 32'd3);
    step(1, 1); chk("ldv_b1", 32'(out_b), 32'd0);
    step(1, 1); chk("ldv_b2", 32'(out_b), 32'd0);
    step(1, 1); chk("ldv_b3", 32'(out_b), 32'd0);
    step(1, 1); chk("ldv_b4", 32'(out_b), 32'd1);
    chk("ldv_cnt2", 32'(cnt_b), 32'd4);
    chk("ldv_sat", 32'(sat_b), 32'd0);

    // Mid-stream reset after 1,0 (instance a holds loaded 111); default 101 returns
    step(1, 1);
    step(1, 0);
    do_reset(1);
    chk("mr_out", 32'(out_a), 32'd0);
    chk("mr_cnt", 32'(cnt_a), 32'd0);
    step(1, 1); chk("mr_b1", 32'(out_a), 32'd0);
    step(1, 0); chk("mr_b2", 32'(out_a), 32'd0);
    step(1, 1); chk("mr_b3", 32'(out_a), 32'd1);
    chk("mr_cnt2", 32'(cnt_a), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
